// File: rtl/laser_pkg.sv
// laser_pkg: shared defaults, helper functions and FSM state codes for the LASER hit counter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package laser_pkg;

  localparam int DEF_COORD_W = 4;
  localparam int DEF_RADIUS  = 4;
  localparam int DEF_MAX_PTS = 40;

  // FSM state codes, kept as plain constants so older tools can consume them.
  typedef logic [1:0] state_t;
  localparam state_t S_IDLE  = 2'd0;
  localparam state_t S_RUN   = 2'd1;
  localparam state_t S_DRAIN = 2'd2;
  localparam state_t S_DONE  = 2'd3;

  // Counter width able to hold 0..max_pts.
  function automatic int cnt_w(input int max_pts);
    return $clog2(max_pts + 1);
  endfunction

  function automatic int r_sq(input int radius);
    return radius * radius;
  endfunction

endpackage

// File: rtl/laser_sq_dist.sv
// laser_sq_dist: two-stage pipe computing dx/dy (S1) then dx^2+dy^2 <= R_SQ (S2).
// Latency: 2 cycles from i_vld to o_vld; one point per cycle, no bubbles.
// Backpressure: none; every valid input emerges two cycles later (reset flushes the pipe).
// Ports: i_clk/i_rst (sync, active-high), i_vld/i_last/i_px/i_py point in,
//   i_cx/i_cy latched centre, o_vld/o_hit/o_last S2 result.
module laser_sq_dist #(
  parameter int COORD_W = 4,
  parameter int R_SQ    = 16
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_vld,
  input  logic               i_last,
  input  logic [COORD_W-1:0] i_px,
  input  logic [COORD_W-1:0] i_py,
  input  logic [COORD_W-1:0] i_cx,
  input  logic [COORD_W-1:0] i_cy,
  output logic               o_vld,
  output logic               o_hit,
  output logic               o_last
);

  localparam int D_W   = COORD_W + 1;        // signed difference width
  localparam int SQ_W  = 2 * D_W;            // signed square width
  localparam int DSQ_W = 2 * COORD_W + 3;    // sum of two squares, never overflows
  localparam logic [DSQ_W-1:0] R_SQ_V = DSQ_W'(R_SQ);

  logic signed [D_W-1:0]  w_dx, w_dy;
  logic signed [D_W-1:0]  r_dx, r_dy;
  logic                   r_s1_vld, r_s1_last;
  logic signed [SQ_W-1:0] w_dx_ext, w_dy_ext, w_dx_sq, w_dy_sq;
  logic [DSQ_W-1:0]       w_dsq;
  logic                   w_hit;
  logic                   r_s2_vld, r_s2_hit, r_s2_last;

  // Zero-extend each coordinate by one bit before going signed so that
  // large unsigned coordinates never read as negative.
  assign w_dx = $signed({1'b0, i_px}) - $signed({1'b0, i_cx});
  assign w_dy = $signed({1'b0, i_py}) - $signed({1'b0, i_cy});

  // Explicit sign extension to the product width keeps the multiply fully signed.
  assign w_dx_ext = {{D_W{r_dx[D_W-1]}}, r_dx};
  assign w_dy_ext = {{D_W{r_dy[D_W-1]}}, r_dy};
  assign w_dx_sq  = w_dx_ext * w_dx_ext;
  assign w_dy_sq  = w_dy_ext * w_dy_ext;

  // Squares are non-negative, so zero-extending them into the sum is exact.
  assign w_dsq = {{(DSQ_W-SQ_W){1'b0}}, w_dx_sq} + {{(DSQ_W-SQ_W){1'b0}}, w_dy_sq};
  assign w_hit = (w_dsq <= R_SQ_V);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s1_vld  <= 1'b0;
      r_s1_last <= 1'b0;
      r_dx      <= '0;
      r_dy      <= '0;
      r_s2_vld  <= 1'b0;
      r_s2_hit  <= 1'b0;
      r_s2_last <= 1'b0;
    end else begin
      r_s1_vld  <= i_vld;
      r_s1_last <= i_vld & i_last;
      r_dx      <= w_dx;
      r_dy      <= w_dy;
      r_s2_vld  <= r_s1_vld;
      r_s2_hit  <= r_s1_vld & w_hit;
      r_s2_last <= r_s1_vld & r_s1_last;
    end
  end

  assign o_vld  = r_s2_vld;
  assign o_hit  = r_s2_hit;
  assign o_last = r_s2_last;

endmodule

// File: rtl/laser_hit_counter.sv
// laser_hit_counter: counts streamed grid points within RADIUS of a latched centre.
// Latency: point accepted at edge k is counted at edge k+2; done pulses after edge k+2 of the last point.
// Backpressure: pt_ready high only in RUN; one point per cycle while ready.
// Ports: CLK, RST (sync, active-high); start/cx/cy begin a run; pt_valid/pt_ready/px/py/pt_last
//   point stream; busy/done/count status. Optional macro HIT_STREAM_EN adds hit_valid/hit
//   per-point result outputs driven from the second pipe stage.
module laser_hit_counter
  import laser_pkg::*;
#(
  parameter int  COORD_W = DEF_COORD_W,
  parameter int  RADIUS  = DEF_RADIUS,
  parameter int  MAX_PTS = DEF_MAX_PTS,
  localparam int CNT_W   = cnt_w(MAX_PTS)
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               start,
  input  logic [COORD_W-1:0] cx,
  input  logic [COORD_W-1:0] cy,
  input  logic               pt_valid,
  output logic               pt_ready,
  input  logic [COORD_W-1:0] px,
  input  logic [COORD_W-1:0] py,
  input  logic               pt_last,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   count
`ifdef HIT_STREAM_EN
  ,
  output logic               hit_valid,
  output logic               hit
`endif
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t             r_state;
  logic [COORD_W-1:0] r_cx, r_cy;
  logic [CNT_W-1:0]   r_count;
  logic               r_done;
  logic               w_accept;
  logic               w_s2_vld, w_s2_hit, w_s2_last;

  assign w_accept = pt_valid & (r_state == S_RUN);

  laser_sq_dist #(
    .COORD_W (COORD_W),
    .R_SQ    (r_sq(RADIUS))
  ) u_sq_dist (
    .i_clk  (CLK),
    .i_rst  (RST),
    .i_vld  (w_accept),
    .i_last (pt_last),
    .i_px   (px),
    .i_py   (py),
    .i_cx   (r_cx),
    .i_cy   (r_cy),
    .o_vld  (w_s2_vld),
    .o_hit  (w_s2_hit),
    .o_last (w_s2_last)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_cx    <= '0;
      r_cy    <= '0;
      r_count <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      // The pipe is always empty in IDLE/DONE, so an increment can never
      // collide with the clear on start.
      if (w_s2_vld && w_s2_hit && (r_count != CNT_MAX)) begin
        r_count <= r_count + CNT_W'(1);
      end
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state <= S_RUN;
            r_cx    <= cx;
            r_cy    <= cy;
            r_count <= '0;
          end
        end
        S_RUN: begin
          if (w_accept && pt_last) begin
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          // The last point retires on the same edge its hit lands in count.
          if (w_s2_vld && w_s2_last) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign pt_ready = (r_state == S_RUN);
  assign busy     = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign done     = r_done;
  assign count    = r_count;

`ifdef HIT_STREAM_EN
  assign hit_valid = w_s2_vld;
  assign hit       = w_s2_hit;
`endif

endmodule
